// File: rtl/detector_filter.sv
`default_nettype none
// ============================================================================
// Module   : detector_filter
// Purpose  : Synchronise and debounce four maze obstacle sensors and publish
//            a coherent 4-bit blocked/open vector to the auto-drive logic.
// Options  : DETECTOR_GLITCH_CNT_EN adds the saturating glitch_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module detector_filter #(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned TICK_HZ        = 1000,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned CNT_W          = 5,
  parameter int unsigned GLITCH_W       = 8
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       power,
  input  logic [1:0] global_state,
  input  logic [3:0] raw_detector,
  output logic [3:0] turn_detector,
  output logic       detector_valid,
  output logic       detector_change
`ifdef DETECTOR_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam int unsigned        c_presc     = CLK_HZ / TICK_HZ;
  localparam int unsigned        c_pw        = (c_presc > 1) ? $clog2(c_presc) : 1;
  localparam logic [c_pw-1:0]    c_presc_max = c_pw'(c_presc - 1);
  localparam logic [CNT_W-1:0]   c_deb       = CNT_W'(DEBOUNCE_TICKS);

  generate
    if ((c_presc < 2) || (DEBOUNCE_TICKS < 1) ||
        (DEBOUNCE_TICKS > ((2 ** CNT_W) - 1)) || (GLITCH_W < 3)) begin : g_param_check
      $error("detector_filter: illegal parameter combination");
    end
  endgenerate

  logic [3:0]            r_sync1;
  logic [3:0]            r_sync2;
  logic [3:0]            r_cand;
  logic [3:0][CNT_W-1:0] r_cnt;
  logic [c_pw-1:0]       r_presc;
  logic [3:0]            r_turn;
  logic                  r_valid;
  logic                  r_change;

  logic       w_en;
  logic       w_tick;
  logic [3:0] w_diff;
  logic [3:0] w_stable;
  logic       w_all_stable;
  logic       w_publish;

  assign w_en   = power & (global_state == 2'b11);
  assign w_tick = (r_presc == c_presc_max);
  assign w_diff = r_sync2 ^ r_cand;

  always_comb begin
    w_stable = '0;
    for (int i = 0; i < 4; i++) begin
      w_stable[i] = (r_cnt[i] == c_deb);
    end
  end

  assign w_all_stable = &w_stable;
  assign w_publish    = w_all_stable & ((r_cand != r_turn) | ~r_valid);

  // Raw lines are fully asynchronous; reset to "blocked" so nothing looks open early.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= raw_detector;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + c_pw'(1);
    end
  end

  // A level change always wins over a coincident tick so the window restarts cleanly.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_cand <= 4'b1111;
      r_cnt  <= '0;
    end else if (!w_en) begin
      r_cand <= r_sync2;
      r_cnt  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_diff[i]) begin
          r_cand[i] <= r_sync2[i];
          r_cnt[i]  <= '0;
        end else if (w_tick && (r_cnt[i] < c_deb)) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_turn   <= 4'b1111;
      r_valid  <= 1'b0;
      r_change <= 1'b0;
    end else if (!w_en) begin
      r_turn   <= 4'b1111;
      r_valid  <= 1'b0;
      r_change <= 1'b0;
    end else begin
      r_change <= w_publish;
      if (w_publish) begin
        r_turn  <= r_cand;
        r_valid <= 1'b1;
      end
    end
  end

  assign turn_detector   = r_turn;
  assign detector_valid  = r_valid;
  assign detector_change = r_change;

`ifdef DETECTOR_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] r_glitch;
  logic [2:0]          w_glitch_inc;
  logic [GLITCH_W:0]   w_glitch_sum;

  // Only a flip that interrupts a partly filled window counts as a glitch.
  always_comb begin
    w_glitch_inc = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_en && w_diff[i] && (r_cnt[i] != '0) && (r_cnt[i] < c_deb)) begin
        w_glitch_inc = w_glitch_inc + 3'd1;
      end
    end
  end

  assign w_glitch_sum = {1'b0, r_glitch} + (GLITCH_W + 1)'(w_glitch_inc);

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_glitch <= '0;
    end else if (w_glitch_sum[GLITCH_W]) begin
      r_glitch <= '1;
    end else begin
      r_glitch <= w_glitch_sum[GLITCH_W-1:0];
    end
  end

  assign glitch_cnt = r_glitch;
`endif

endmodule
`default_nettype wire

// File: tb/tb_detector_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_detector_filter
// Purpose  : Directed scoreboard bench for detector_filter (PRESC=10, 4 ticks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_detector_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic       power;
  logic [1:0] gs;
  logic [3:0] raw;
  logic [3:0] turn;
  logic       valid;
  logic       change;
`ifdef DETECTOR_GLITCH_CNT_EN
  logic [7:0] glitch;
`endif

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_v;

  always #5 clk = ~clk;

  detector_filter #(
    .CLK_HZ(10_000),
    .TICK_HZ(1000),
    .DEBOUNCE_TICKS(4),
    .CNT_W(5),
    .GLITCH_W(8)
  ) dut (
    .sys_clk(clk),
    .rst(rst),
    .power(power),
    .global_state(gs),
    .raw_detector(raw),
    .turn_detector(turn),
    .detector_valid(valid),
    .detector_change(change)
`ifdef DETECTOR_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch)
`endif
  );

  // Every publish pulse must match the oldest outstanding expected vector.
  always @(negedge clk) begin
    if (rst === 1'b1 && change === 1'b1) begin
      pulses++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_pulse observed=%b expected=no_pulse", turn);
      end
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        assert (turn === exp_v) else begin
          errors++;
          $error("FAIL sb_vector observed=%b expected=%b", turn, exp_v);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_vec(input logic [3:0] v, input int bound, output int n);
    n = 0;
    while (!(turn === v && valid === 1'b1) && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int p;

    rst   = 1'b0;
    power = 1'b1;
    gs    = 2'b11;
    raw   = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_turn", turn, 4'b1111);
    chk("rst_valid", valid, 1'b0);
    chk("rst_change", change, 1'b0);
`ifdef DETECTOR_GLITCH_CNT_EN
    chk("rst_glitch", glitch, 8'd0);
`endif

    // Step 1: first publish after reset release
    exp_q.push_back(4'b0000);
    rst = 1'b1;
    wait_vec(4'b0000, 60, n);
    chk_range("s1_latency", n, 1, 43);
    repeat (10) @(negedge clk);
    chk("s1_pulses", pulses, 1);

    // Step 2: single channel goes blocked
    exp_q.push_back(4'b0100);
    raw = 4'b0100;
    wait_vec(4'b0100, 60, n);
    chk_range("s2_latency", n, 32, 43);
    repeat (2) @(negedge clk);
    chk("s2_pulses", pulses, 2);
    chk("s2_change_low", change, 1'b0);
    p = pulses;
    repeat (200) @(negedge clk);
    chk("s2_quiet_pulses", pulses, p);
    chk("s2_hold_vec", turn, 4'b0100);

    // Step 3: chattering channel never publishes
`ifdef DETECTOR_GLITCH_CNT_EN
    chk("s3_glitch_start", glitch, 8'd0);
`endif
    for (int k = 0; k < 20; k++) begin
      raw[0] = ~raw[0];
      repeat (15) @(negedge clk);
    end
    repeat (60) @(negedge clk);
    chk("s3_vec", turn, 4'b0100);
    chk("s3_valid", valid, 1'b1);
    chk("s3_pulses", pulses, p);
`ifdef DETECTOR_GLITCH_CNT_EN
    chk_range("s3_glitch", int'(glitch), 18, 255);
`endif

    // Step 4: two channels with staggered edges publish once
    exp_q.push_back(4'b0000);
    raw = 4'b0000;
    wait_vec(4'b0000, 60, n);
    chk_range("s4_clear_latency", n, 1, 59);
    repeat (5) @(negedge clk);
    exp_q.push_back(4'b1010);
    raw[1] = 1'b1;
    repeat (25) @(negedge clk);
    raw[3] = 1'b1;
    wait_vec(4'b1010, 80, n);
    chk_range("s4_latency", n, 1, 79);
    repeat (2) @(negedge clk);
    chk("s4_pulses", pulses, 4);

    // Step 5: leave auto mode mid-debounce, then return
    exp_q.push_back(4'b1011);
    raw[0] = 1'b1;
    repeat (15) @(negedge clk);
    gs = 2'b01;
    @(negedge clk);
    chk("s5_dis_vec", turn, 4'b1111);
    chk("s5_dis_valid", valid, 1'b0);
    chk("s5_dis_change", change, 1'b0);
    repeat (5) @(negedge clk);
    gs = 2'b11;
    wait_vec(4'b1011, 60, n);
    chk_range("s5_latency", n, 31, 43);
    repeat (2) @(negedge clk);
    chk("s5_pulses", pulses, 5);

    // Step 6: asynchronous reset in the middle of a count
    exp_q.push_back(4'b0000);
    raw = 4'b0000;
    repeat (15) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("s6_rst_vec", turn, 4'b1111);
    chk("s6_rst_valid", valid, 1'b0);
    chk("s6_rst_change", change, 1'b0);
`ifdef DETECTOR_GLITCH_CNT_EN
    chk("s6_rst_glitch", glitch, 8'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    wait_vec(4'b0000, 60, n);
    chk_range("s6_latency", n, 34, 43);
    repeat (2) @(negedge clk);
    chk("s6_pulses", pulses, 6);
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
